// File: rtl/dpram_pkg.sv
// Shared widths and types for the dual-port RAM slice.
package dpram_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W:0]   occ_t;
endpackage

// File: rtl/dpram_vld_tracker.sv
// Per-entry written flags plus a count of distinct entries written since reset.
// Latency: written_at_rd is combinational from current flags; occupancy is registered.
// Backpressure: none; a write is accepted every cycle.
module dpram_vld_tracker
    import dpram_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_en,
    input  addr_t wr_addr,
    input  addr_t rd_addr,
    output logic  written_at_rd,
    output occ_t  occupancy
);
    logic [DEPTH-1:0] written;

    assign written_at_rd = written[rd_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            written   <= '0;
            occupancy <= '0;
        end else if (wr_en) begin
            written[wr_addr] <= 1'b1;
            // Only first touch of an entry counts; the count saturates at DEPTH naturally.
            if (!written[wr_addr])
                occupancy <= occupancy + occ_t'(1);
        end
    end
endmodule

// File: rtl/dpram_core.sv
// Dual-port RAM with write-first collision bypass, uninitialised-read flag and occupancy.
// Latency: read data one cycle after rd_en is sampled; writes land on the same edge.
// Backpressure: none; both ports accept one request every cycle.
module dpram_core
    import dpram_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_en,
    input  addr_t wr_addr,
    input  data_t data_in,
    input  logic  rd_en,
    input  addr_t rd_addr,
    output data_t data_out,
    output logic  rd_valid,
    output logic  rd_uninit,
    output logic  collision,
    output occ_t  occupancy
);
    data_t mem [DEPTH];
    logic  written_at_rd;
    logic  same_addr_hit;

    assign same_addr_hit = wr_en && rd_en && (wr_addr == rd_addr);

    dpram_vld_tracker u_tracker (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .rd_addr       (rd_addr),
        .written_at_rd (written_at_rd),
        .occupancy     (occupancy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mem <= '{default: '0};
        else if (wr_en)
            mem[wr_addr] <= data_in;
    end

    // Same-address write wins: the reader sees the incoming data, never the stale entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            rd_valid  <= 1'b0;
            rd_uninit <= 1'b0;
            collision <= 1'b0;
        end else begin
            rd_valid  <= rd_en;
            collision <= same_addr_hit;
            if (rd_en) begin
                data_out  <= same_addr_hit ? data_in : mem[rd_addr];
                rd_uninit <= same_addr_hit ? 1'b0 : ~written_at_rd;
            end
        end
    end
endmodule

// File: tb/tb_dpram_core.sv
// Bench for dpram_core: array-based reference model checked every cycle plus directed literals.
module tb_dpram_core;
    import dpram_pkg::*;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    logic  wr_en = 1'b0;
    addr_t wr_addr = '0;
    data_t data_in = '0;
    logic  rd_en = 1'b0;
    addr_t rd_addr = '0;
    data_t data_out;
    logic  rd_valid;
    logic  rd_uninit;
    logic  collision;
    occ_t  occupancy;

    int checks = 0;
    int errors = 0;

    dpram_core dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .data_in   (data_in),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .rd_uninit (rd_uninit),
        .collision (collision),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, written set, and the expected read-side view.
    int m_mem [DEPTH];
    bit m_wr  [DEPTH];
    int e_data;
    bit e_valid, e_uninit, e_coll;

    function automatic int model_occ();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_wr[i];
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = 0;
                m_wr[i]  = 0;
            end
            e_data = 0; e_valid = 0; e_uninit = 0; e_coll = 0;
        end else begin
            e_valid = rd_en;
            e_coll  = rd_en && wr_en && (rd_addr == wr_addr);
            if (rd_en) begin
                e_data   = e_coll ? int'(data_in) : m_mem[rd_addr];
                e_uninit = e_coll ? 1'b0 : !m_wr[rd_addr];
            end
            if (wr_en) begin
                m_mem[wr_addr] = int'(data_in);
                m_wr[wr_addr]  = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cmp_data_out", int'(data_out), e_data);
            chk("cmp_rd_valid", int'(rd_valid), int'(e_valid));
            chk("cmp_rd_uninit", int'(rd_uninit), int'(e_uninit));
            chk("cmp_collision", int'(collision), int'(e_coll));
            chk("cmp_occupancy", int'(occupancy), model_occ());
        end
    end

    // Drive one cycle of inputs, then return just after the following negedge.
    task automatic cyc(input bit we, input int wa, input int wd, input bit re, input int ra);
        wr_en   = we;
        wr_addr = addr_t'(wa);
        data_in = data_t'(wd);
        rd_en   = re;
        rd_addr = addr_t'(ra);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_occupancy", int'(occupancy), 0);
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0);

        // Uninitialised read
        cyc(0, 0, 0, 1, 3);
        chk("t1_data", int'(data_out), 8'h00);
        chk("t1_valid", int'(rd_valid), 1);
        chk("t1_uninit", int'(rd_uninit), 1);
        chk("t1_occ", int'(occupancy), 0);

        // Write then read
        cyc(1, 5, 8'hA5, 0, 0);
        cyc(0, 0, 0, 1, 5);
        chk("t2_data", int'(data_out), 8'hA5);
        chk("t2_uninit", int'(rd_uninit), 0);
        chk("t2_occ", int'(occupancy), 1);

        // Collision bypass, then same-edge traffic to different addresses
        cyc(1, 7, 8'h3C, 1, 7);
        chk("t3_data", int'(data_out), 8'h3C);
        chk("t3_coll", int'(collision), 1);
        chk("t3_uninit", int'(rd_uninit), 0);
        cyc(1, 7, 8'h3C, 1, 8);
        chk("t3b_data", int'(data_out), 8'h00);
        chk("t3b_coll", int'(collision), 0);
        chk("t3b_uninit", int'(rd_uninit), 1);

        // Fill every entry, rewrite one, then back-to-back readback
        for (int a = 0; a < DEPTH; a++) cyc(1, a, a * 8'h11, 0, 0);
        chk("t4_occ_full", int'(occupancy), 16);
        cyc(1, 0, 8'h00, 0, 0);
        chk("t4_occ_rewrite", int'(occupancy), 16);
        for (int a = 0; a < DEPTH; a++) begin
            cyc(0, 0, 0, 1, a);
            chk("t4_rd_valid", int'(rd_valid), 1);
            chk("t4_rd_data", int'(data_out), a * 8'h11);
        end
        chk("t4_occ_after", int'(occupancy), 16);

        // Reset in the middle of a cycle after a read was sampled
        rd_en = 1'b1; rd_addr = 4'd2; wr_en = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_data", int'(data_out), 0);
        chk("t5_valid", int'(rd_valid), 0);
        chk("t5_occ", int'(occupancy), 0);
        @(negedge clk);
        rd_en = 1'b0;
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("t5_no_pulse", int'(rd_valid), 0);
        cyc(0, 0, 0, 1, 2);
        chk("t5_uninit", int'(rd_uninit), 1);
        chk("t5_rd_data", int'(data_out), 0);

        // Mixed traffic with a bias towards same-address collisions
        for (int i = 0; i < 2000; i++) begin
            int wa;
            int ra;
            wa = $urandom_range(0, DEPTH - 1);
            ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
            cyc($urandom_range(0, 1), wa, $urandom_range(0, 255), $urandom_range(0, 1), ra);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
